// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencing, lock qualification and downstream reset release
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 32,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 270000,
    parameter int MAX_RETRY           = 7
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       out_rst,
    output logic       clk_ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam int PMAX = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int TW   = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] RST_LAST  = PW'(RST_PULSE_CYCLES - 1);
    localparam logic [PW-1:0] STB_LAST  = PW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(LOCK_TIMEOUT_CYCLES);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]    retry_q, retry_d, retry_inc;
    logic          pll_reset_q, pll_reset_d;
    logic          out_rst_q, out_rst_d;
    logic          clk_ready_q, clk_ready_d;
    logic          fail_q, fail_d;
    logic          lock_s, timeout, enter, keep_tmo;

    assign lock_s    = sync2_q;
    assign timeout   = (tmo_cnt_q >= TMO_LIMIT);
    assign retry_inc = retry_q + 4'd1;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        sync1_d = pll_lock;
        sync2_d = sync1_q;
        if (relock_req) begin
            state_d = S_RESET;
            if (state_q == S_FAIL) retry_d = 4'd0;
        end else begin
            case (state_q)
                S_RESET: if (pulse_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                    end else if (timeout) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;
                    end
                end
                // Timeout wins over a glitch so tmo_cnt can never run past the limit unnoticed.
                S_STABLE: begin
                    if (timeout) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;
                    end else if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (pulse_cnt_q == STB_LAST) begin
                        state_d = S_RUN;
                        retry_d = 4'd0;
                    end
                end
                S_RUN:   if (!lock_s) state_d = S_RESET;
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_RESET;
            endcase
        end

        enter    = (state_d != state_q) || relock_req;
        keep_tmo = ((state_q == S_WAIT_LOCK) && (state_d == S_STABLE)) ||
                   ((state_q == S_STABLE) && (state_d == S_WAIT_LOCK));

        if (enter)
            pulse_cnt_d = '0;
        else if ((state_q == S_RESET) || (state_q == S_STABLE))
            pulse_cnt_d = pulse_cnt_q + 1'b1;
        else
            pulse_cnt_d = pulse_cnt_q;

        if (enter && !keep_tmo)
            tmo_cnt_d = '0;
        else if ((state_q == S_WAIT_LOCK) || (state_q == S_STABLE))
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        else
            tmo_cnt_d = tmo_cnt_q;

        pll_reset_d = (state_d == S_RESET) || (state_d == S_FAIL);
        out_rst_d   = (state_d != S_RUN);
        clk_ready_d = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= S_RESET;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            pulse_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= 4'd0;
            pll_reset_q <= 1'b1;
            out_rst_q   <= 1'b1;
            clk_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pulse_cnt_q <= pulse_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            out_rst_q   <= out_rst_d;
            clk_ready_q <= clk_ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign out_rst   = out_rst_q;
    assign clk_ready = clk_ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - directed bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_reset;
    logic       out_rst;
    logic       clk_ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(64),
        .MAX_RETRY          (2)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .relock_req(relock_req),
        .pll_reset (pll_reset),
        .out_rst   (out_rst),
        .clk_ready (clk_ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each step crosses exactly one rising edge; sampling and driving happen on negedges.
    task automatic step(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        check({tag, "_out_rst"}, 32'(out_rst), 32'd1);
        check({tag, "_clk_ready"}, 32'(clk_ready), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    endtask

    // Release reset, pulse of 4, raise lock 10 cycles after release, ready 11 edges later.
    task automatic nominal(input string tag);
        reset = 1'b0;
        step(3);
        check({tag, "_prst_hi3"}, 32'(pll_reset), 32'd1);
        step(1);
        check({tag, "_prst_lo4"}, 32'(pll_reset), 32'd0);
        check({tag, "_wait"}, 32'(state), 32'd1);
        step(6);
        pll_lock = 1'b1;
        step(3);
        check({tag, "_stable"}, 32'(state), 32'd2);
        step(7);
        check({tag, "_rdy_e10"}, 32'(clk_ready), 32'd0);
        step(1);
        check({tag, "_rdy_e11"}, 32'(clk_ready), 32'd1);
        check({tag, "_orst_e11"}, 32'(out_rst), 32'd0);
        check({tag, "_run"}, 32'(state), 32'd3);
        check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    endtask

    initial begin
        int guard;
        reset      = 1'b1;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        step(2);
        check_reset_vals("por");

        // 1. nominal
        nominal("nom");

        // 4. lock loss in RUN
        pll_lock = 1'b0;
        step(2);
        check("loss_rdy_e2", 32'(clk_ready), 32'd1);
        step(1);
        check("loss_rdy_e3", 32'(clk_ready), 32'd0);
        check("loss_orst_e3", 32'(out_rst), 32'd1);
        check("loss_prst_e3", 32'(pll_reset), 32'd1);
        check("loss_state", 32'(state), 32'd0);
        step(3);
        check("loss_prst_hi", 32'(pll_reset), 32'd1);
        step(1);
        check("loss_prst_lo", 32'(pll_reset), 32'd0);
        pll_lock = 1'b1;
        step(11);
        check("loss_relock_rdy", 32'(clk_ready), 32'd1);
        check("loss_retry", 32'(retry_cnt), 32'd0);

        // relock_req in RUN drops clk_ready on the next edge
        relock_req = 1'b1;
        pll_lock   = 1'b0;
        step(1);
        relock_req = 1'b0;
        check("rlk_rdy", 32'(clk_ready), 32'd0);
        check("rlk_state", 32'(state), 32'd0);
        step(4);
        check("rlk_wait", 32'(state), 32'd1);

        // 2. lock glitch
        pll_lock = 1'b1;
        step(5);
        check("gl_stable", 32'(state), 32'd2);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(2);
        check("gl_back_wait", 32'(state), 32'd1);
        step(1);
        check("gl_restable", 32'(state), 32'd2);
        step(7);
        check("gl_rdy_e10", 32'(clk_ready), 32'd0);
        step(1);
        check("gl_rdy_e11", 32'(clk_ready), 32'd1);

        // 5. relock_req beats stability completion
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        step(4);
        check("pri_wait", 32'(state), 32'd1);
        step(1);
        check("pri_stable", 32'(state), 32'd2);
        step(7);
        check("pri_pre", 32'(state), 32'd2);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        check("pri_state", 32'(state), 32'd0);
        check("pri_rdy", 32'(clk_ready), 32'd0);

        // 6. async reset mid-STABLE
        step(5);
        check("ar_stable", 32'(state), 32'd2);
        #2 reset = 1'b1;
        pll_lock = 1'b0;
        #1 check_reset_vals("ar");
        @(negedge clkin);
        nominal("ar_nom");

        // 3. timeout / retry into FAIL
        reset    = 1'b1;
        pll_lock = 1'b0;
        step(1);
        reset = 1'b0;
        guard = 0;
        while (retry_cnt != 4'd1 && guard < 300) begin
            step(1);
            guard++;
        end
        check("to_retry1", 32'(retry_cnt), 32'd1);
        check("to_r1_state", 32'(state), 32'd0);
        check("to_r1_prst", 32'(pll_reset), 32'd1);
        step(3);
        check("to_pulse_hi", 32'(pll_reset), 32'd1);
        step(1);
        check("to_pulse_lo", 32'(pll_reset), 32'd0);
        guard = 0;
        while (retry_cnt != 4'd2 && guard < 300) begin
            step(1);
            guard++;
        end
        check("to_retry2", 32'(retry_cnt), 32'd2);
        check("to_fail_state", 32'(state), 32'd4);
        check("to_fail", 32'(fail), 32'd1);
        step(5);
        check("to_fail_hold", 32'(state), 32'd4);
        check("to_fail_prst", 32'(pll_reset), 32'd1);
        check("to_fail_orst", 32'(out_rst), 32'd1);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        check("to_clr_retry", 32'(retry_cnt), 32'd0);
        check("to_clr_state", 32'(state), 32'd0);
        check("to_clr_fail", 32'(fail), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
